// File: rtl/vga_timing_if.sv
// Raster timing bundle produced by vga_timing_gen and consumed by the RGB mux
// and the VGA pin stage.
interface vga_timing_if;
    logic        pixel_tick;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        active;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        line_start;
    logic        frame_start;
    logic [15:0] frame_count;

    modport master (
        output pixel_tick, x, y, active, hsync, vsync, de,
               line_start, frame_start, frame_count
    );

    modport slave (
        input  pixel_tick, x, y, active, hsync, vsync, de,
               line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, horizontal/vertical
// counters, visible/sync decode and an alignment pipeline that keeps
// hsync/vsync/de in step with the RGB mux's registered output.
module vga_timing_gen #(
    parameter int CLK_DIV    = 4,
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int PIPE_DELAY = 1
) (
    input  logic          clk,
    input  logic          reset,
    vga_timing_if.master  vid
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    // Pipeline reset word, packed as {hsync, vsync, de}
    localparam logic [2:0] PIPE_RST = {~SYNC_POL, ~SYNC_POL, 1'b0};

    // run_q releases one edge after reset drops, so the release edge itself
    // never advances the divider.
    logic        run_q, run_d;
    logic [3:0]  div_cnt_q, div_cnt_d;
    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic [15:0] frame_count_q, frame_count_d;

    logic        pixel_tick;
    logic        line_wrap;
    logic        frame_wrap;
    logic        active_raw;
    logic        hsync_raw;
    logic        vsync_raw;
    logic        de_raw;
    logic [2:0]  pipe_in;
    logic [2:0]  pipe_out;

    // Divider, counters, wrap pulses and frame counter next-state
    always_comb begin
        run_d         = 1'b1;
        div_cnt_d     = div_cnt_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        pixel_tick    = run_q && (div_cnt_q == DIV_LAST);
        line_wrap     = pixel_tick && (h_cnt_q == H_LAST);
        frame_wrap    = line_wrap && (v_cnt_q == V_LAST);
        if (run_q) begin
            div_cnt_d = (div_cnt_q == DIV_LAST) ? 4'd0 : 4'(div_cnt_q + 4'd1);
        end
        if (pixel_tick) begin
            h_cnt_d = line_wrap ? 10'd0 : 10'(h_cnt_q + 10'd1);
            if (line_wrap) begin
                v_cnt_d = frame_wrap ? 10'd0 : 10'(v_cnt_q + 10'd1);
            end
        end
        line_start_d  = line_wrap;
        frame_start_d = frame_wrap;
        frame_count_d = 16'(frame_count_q + {15'd0, frame_wrap});
    end

    // Timing state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q         <= 1'b0;
            div_cnt_q     <= 4'd0;
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            run_q         <= run_d;
            div_cnt_q     <= div_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Visible-area and sync decode; the pipeline input is held idle until the
    // raster is running so de never reports the frozen (0,0) reset position.
    always_comb begin
        active_raw = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        hsync_raw  = ~SYNC_POL;
        vsync_raw  = ~SYNC_POL;
        if (run_q && (h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) begin
            hsync_raw = SYNC_POL;
        end
        if (run_q && (v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) begin
            vsync_raw = SYNC_POL;
        end
        de_raw  = run_q && active_raw;
        pipe_in = {hsync_raw, vsync_raw, de_raw};
    end

    generate
        if (PIPE_DELAY == 0) begin : g_bypass
            assign pipe_out = pipe_in;
        end else begin : g_pipe
            for (genvar gi = 0; gi < PIPE_DELAY; gi++) begin : g_stage
                logic [2:0] stage_d;
                logic [2:0] stage_q;
                if (gi == 0) begin : g_first
                    // First stage samples the raw decode
                    always_comb stage_d = pipe_in;
                end else begin : g_next
                    // Later stages take the previous stage
                    always_comb stage_d = g_stage[gi-1].stage_q;
                end
                // Alignment stage, shifts every clk
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        stage_q <= PIPE_RST;
                    end else begin
                        stage_q <= stage_d;
                    end
                end
            end
            assign pipe_out = g_stage[PIPE_DELAY-1].stage_q;
        end
    endgenerate

    assign vid.pixel_tick  = pixel_tick;
    assign vid.active      = active_raw;
    assign vid.x           = active_raw ? h_cnt_q : 10'd0;
    assign vid.y           = active_raw ? v_cnt_q : 10'd0;
    assign vid.hsync       = pipe_out[2];
    assign vid.vsync       = pipe_out[1];
    assign vid.de          = pipe_out[0];
    assign vid.line_start  = line_start_q;
    assign vid.frame_start = frame_start_q;
    assign vid.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken raster so several frames fit
// in a short run. Raster A: CLK_DIV=4, H 16/2/4/3 (25), V 12/2/2/3 (19),
// PIPE_DELAY=1 -> 100 clk per line, 1900 clk per frame. Raster B: same
// geometry with CLK_DIV=1 and PIPE_DELAY=2.
module tb_vga_timing_gen;

    logic clk;
    logic reset;

    vga_timing_if vid_a ();
    vga_timing_if vid_b ();

    vga_timing_gen #(
        .CLK_DIV(4), .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VISIBLE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(1'b0), .PIPE_DELAY(1)
    ) dut_a (
        .clk(clk), .reset(reset), .vid(vid_a)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VISIBLE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(1'b0), .PIPE_DELAY(2)
    ) dut_b (
        .clk(clk), .reset(reset), .vid(vid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic track(inout int mn, inout int mx, input int v);
        if (v < mn) mn = v;
        if (v > mx) mx = v;
    endtask

    // Measurement state for the free-running section
    int last_ls, last_fs, hs_fall, de_rise, vs_fall, b_fall;
    int ls_n, fs_n, hs_n, de_n, vs_n, de_cnt;
    int ls_mn, ls_mx, hs_off_mn, hs_off_mx, hs_len_mn, hs_len_mx;
    int de_off_mn, de_off_mx, de_len_mn, de_len_mx;
    int vs_off_mn, vs_off_mx, vs_len_mn, vs_len_mx;
    logic hs_prev, de_prev, vs_prev, hsb_prev;
    logic [11:0] tick_a, tick_b;
    int fs_cyc;
    logic fs_seen;

    initial begin
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Reset state
        check("rst_x", 32'(vid_a.x), 0);
        check("rst_y", 32'(vid_a.y), 0);
        check("rst_active", 32'(vid_a.active), 1);
        check("rst_hsync", 32'(vid_a.hsync), 1);
        check("rst_vsync", 32'(vid_a.vsync), 1);
        check("rst_de", 32'(vid_a.de), 0);
        check("rst_frame_count", 32'(vid_a.frame_count), 0);
        check("rst_tick", 32'(vid_a.pixel_tick), 0);
        check("rst_tick_b", 32'(vid_b.pixel_tick), 0);
        check("rst_hsync_b", 32'(vid_b.hsync), 1);

        reset = 1'b0;

        last_ls = 0; last_fs = 0; hs_fall = 0; de_rise = 0; vs_fall = 0; b_fall = -1;
        ls_n = 0; fs_n = 0; hs_n = 0; de_n = 0; vs_n = 0; de_cnt = 0;
        ls_mn = 1 << 30; ls_mx = -1; hs_off_mn = 1 << 30; hs_off_mx = -1;
        hs_len_mn = 1 << 30; hs_len_mx = -1; de_off_mn = 1 << 30; de_off_mx = -1;
        de_len_mn = 1 << 30; de_len_mx = -1; vs_off_mn = 1 << 30; vs_off_mx = -1;
        vs_len_mn = 1 << 30; vs_len_mx = -1;
        hs_prev = 1'b1; de_prev = 1'b0; vs_prev = 1'b1; hsb_prev = 1'b1;
        tick_a = '0; tick_b = '0;

        // Free-running raster: three full frames plus part of a fourth
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            if (cyc < 12) begin
                tick_a[cyc] = vid_a.pixel_tick;
                tick_b[cyc] = vid_b.pixel_tick;
            end
            if (cyc == 4) begin
                check("x_c4", 32'(vid_a.x), 1);
                check("y_c4", 32'(vid_a.y), 0);
            end
            if (cyc == 63) check("active_h15", 32'(vid_a.active), 1);
            if (cyc == 64) check("active_h16", 32'(vid_a.active), 0);
            if (cyc == 308) begin
                check("x_l3", 32'(vid_a.x), 2);
                check("y_l3", 32'(vid_a.y), 3);
            end
            if (vid_a.line_start) begin
                track(ls_mn, ls_mx, cyc - last_ls);
                ls_n++;
                last_ls = cyc;
            end
            if (hs_prev && !vid_a.hsync) begin
                track(hs_off_mn, hs_off_mx, cyc - last_ls);
                hs_fall = cyc;
                hs_n++;
            end
            if (!hs_prev && vid_a.hsync) track(hs_len_mn, hs_len_mx, cyc - hs_fall);
            if (!de_prev && vid_a.de) begin
                track(de_off_mn, de_off_mx, cyc - last_ls);
                de_rise = cyc;
                de_n++;
            end
            if (de_prev && !vid_a.de) track(de_len_mn, de_len_mx, cyc - de_rise);
            if (vs_prev && !vid_a.vsync) begin
                track(vs_off_mn, vs_off_mx, cyc - last_fs);
                vs_fall = cyc;
                vs_n++;
            end
            if (!vs_prev && vid_a.vsync) track(vs_len_mn, vs_len_mx, cyc - vs_fall);
            if (vid_a.frame_start) begin
                fs_n++;
                check("fs_period", 32'(cyc - last_fs), 1900);
                check("fc_at_fs", 32'(vid_a.frame_count), 32'(fs_n));
                check("ls_with_fs", 32'(vid_a.line_start), 1);
                check("de_per_frame", 32'(de_cnt), 768);
                de_cnt = 0;
                last_fs = cyc;
            end
            if (hsb_prev && !vid_b.hsync && b_fall < 0) b_fall = cyc;
            de_cnt += int'(vid_a.de);
            hs_prev = vid_a.hsync;
            de_prev = vid_a.de;
            vs_prev = vid_a.vsync;
            hsb_prev = vid_b.hsync;
        end

        check("tick_pattern", 32'(tick_a), 32'h888);
        check("tick_pattern_b", 32'(tick_b), 32'hfff);
        check("hsync_fall_b", 32'(b_fall), 20);
        check("ls_count", 32'(ls_n), 59);
        check("ls_period_min", 32'(ls_mn), 100);
        check("ls_period_max", 32'(ls_mx), 100);
        check("fs_count", 32'(fs_n), 3);
        check("hs_count", 32'(hs_n), 60);
        check("hs_off_min", 32'(hs_off_mn), 73);
        check("hs_off_max", 32'(hs_off_mx), 73);
        check("hs_low_min", 32'(hs_len_mn), 16);
        check("hs_low_max", 32'(hs_len_mx), 16);
        check("de_count", 32'(de_n), 39);
        check("de_off_min", 32'(de_off_mn), 1);
        check("de_off_max", 32'(de_off_mx), 1);
        check("de_len_min", 32'(de_len_mn), 64);
        check("de_len_max", 32'(de_len_mx), 64);
        check("vs_count", 32'(vs_n), 3);
        check("vs_off_min", 32'(vs_off_mn), 1401);
        check("vs_off_max", 32'(vs_off_mx), 1401);
        check("vs_low_min", 32'(vs_len_mn), 200);
        check("vs_low_max", 32'(vs_len_mx), 200);

        // Frame counter wrap from a preloaded 65535
        force dut_a.frame_count_q = 16'hffff;
        @(negedge clk);
        release dut_a.frame_count_q;
        @(negedge clk);
        check("fc_preload", 32'(vid_a.frame_count), 32'hffff);
        fs_seen = 1'b0;
        for (int i = 0; i < 2000 && !fs_seen; i++) begin
            @(negedge clk);
            if (vid_a.frame_start) begin
                fs_seen = 1'b1;
                check("fc_wrap", 32'(vid_a.frame_count), 0);
            end
        end
        check("fc_wrap_fs_seen", 32'(fs_seen), 1);

        // Mid-frame reset at h=20, v=15 (inside both sync pulses)
        repeat (1580) @(negedge clk);
        check("pre_rst_hsync", 32'(vid_a.hsync), 0);
        check("pre_rst_vsync", 32'(vid_a.vsync), 0);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_hsync", 32'(vid_a.hsync), 1);
        check("mid_rst_vsync", 32'(vid_a.vsync), 1);
        check("mid_rst_h_cnt", 32'(dut_a.h_cnt_q), 0);
        check("mid_rst_v_cnt", 32'(dut_a.v_cnt_q), 0);
        check("mid_rst_de", 32'(vid_a.de), 0);
        check("mid_rst_active", 32'(vid_a.active), 1);
        check("mid_rst_tick", 32'(vid_a.pixel_tick), 0);
        check("mid_rst_fc", 32'(vid_a.frame_count), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Restart: same first-tick timing, first frame_start a full frame later
        tick_a = '0; tick_b = '0; fs_cyc = -1;
        for (int cyc = 0; cyc < 1901; cyc++) begin
            @(negedge clk);
            if (cyc < 12) begin
                tick_a[cyc] = vid_a.pixel_tick;
                tick_b[cyc] = vid_b.pixel_tick;
            end
            if (cyc == 4) check("restart_x_c4", 32'(vid_a.x), 1);
            if (vid_a.frame_start && fs_cyc < 0) begin
                fs_cyc = cyc;
                check("restart_fc", 32'(vid_a.frame_count), 1);
            end
        end
        check("restart_tick", 32'(tick_a), 32'h888);
        check("restart_tick_b", 32'(tick_b), 32'hfff);
        check("restart_fs_cycle", 32'(fs_cyc), 1900);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
